alu_seq_top: RTL and testbench

Sequential, parametrised successor to the project's combinational ALU display top. It accepts an operation with a start pulse and runs add or subtract in one cycle. Multiply and divide are iterative and take WIDTH cycles each. The block holds the result in a register and reports completion with busy/done. It drives the LED bank and the active-low seven-segment digits from either the registered result or the live operands, and can blink the error banner.

---
 rtl/alu_seq_top.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_seq_top.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_top.sv
// Sequential add/sub/mul/div ALU with LED and active-low seven-segment display.
// Optional error-banner blinking is built when ERR_BLINK_EN is defined.
module alu_seq_top #(
   parameter int WIDTH     = 6,
   parameter int N_SEGS    = 8,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   input  logic [2:0]            func,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [2*WIDTH-1:0]    leds,
   output logic [7*N_SEGS-1:0]   segs,
   output logic                  err,
   output logic [2:0]            dbg_state_o
);

   localparam int W2   = 2 * WIDTH;
   localparam int M    = WIDTH - 1;
   localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADD  = 3'd1,
      S_MUL  = 3'd2,
      S_DIV  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   // Handshake: start is taken only while busy=0; busy stays high from the
   // accepting edge through the single done cycle; starts seen while busy are dropped.
   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    result_q, result_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_ovf;
   logic [W2-1:0]    acc_next;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] rem_next, quo_next;

   function automatic logic [W2-1:0] mag_ext(input logic [WIDTH-1:0] v);
      logic [W2-1:0] s;
      s = {{WIDTH{v[M]}}, v};
      return v[M] ? -s : s;
   endfunction

   assign add_sum = op_q[0] ? (a_q - b_q) : (a_q + b_q);
   assign add_ovf = op_q[0] ? ((a_q[M] != b_q[M]) && (add_sum[M] != a_q[M]))
                            : ((a_q[M] == b_q[M]) && (add_sum[M] != a_q[M]));

   assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Restoring step: bring in the next dividend bit, subtract only if it fits.
   assign div_shift = {rem_q, quo_q[M]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
   assign quo_next  = {quo_q[WIDTH-2:0], div_ge};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = func[1:0];
               a_d      = a;
               b_d      = b;
               err_d    = 1'b0;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = mag_ext(a);
               mplier_d = mag_ext(b);
               neg_d    = a[M] ^ b[M];
               quo_d    = a;
               rem_d    = '0;
               case (func[1:0])
                  2'b10:   state_d = S_MUL;
                  2'b11:   state_d = S_DIV;
                  default: state_d = S_ADD;
               endcase
            end
         end
         S_ADD: begin
            result_d = {{WIDTH{add_sum[M]}}, add_sum};
            err_d    = add_ovf;
            state_d  = S_FIN;
         end
         S_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               result_d = neg_q ? -acc_next : acc_next;
               state_d  = S_FIN;
            end
         end
         S_DIV: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               result_d = (b_q == '0) ? '0 : {quo_next, rem_next};
               err_d    = (b_q == '0);
               state_d  = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FIN);
   assign err         = err_q;
   assign dbg_state_o = state_q;

   logic banner_on;

`ifdef ERR_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;

   // Restarting on err rising makes every banner begin with a visible phase.
   always_ff @(posedge clk) begin
      if (rst || (err_d && !err_q)) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end
   assign banner_on = ~phase_q;
`else
   localparam int unused_blink_div = BLINK_DIV;
   assign banner_on = 1'b1;
`endif

   // Digit codes: 0-9 decimal, A minus, B 'E', C 'r', D 'o', E/F blank.
   function automatic logic [6:0] bcd2seg(input logic [3:0] c);
      case (c)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h40;
         4'hB: return 7'h79;
         4'hC: return 7'h50;
         4'hD: return 7'h5C;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [15:0] bin2bcd(input logic [W2-1:0] bin);
      logic [15:0] bcd;
      bcd = '0;
      for (int i = W2 - 1; i >= 0; i--) begin
         for (int d = 0; d < 4; d++)
            if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         bcd = {bcd[14:0], bin[i]};
      end
      return bcd;
   endfunction

   // {sign, tens, units} for a WIDTH-bit value; a zero tens digit is blanked.
   function automatic logic [11:0] fmt2(input logic [WIDTH-1:0] v, input logic sgn);
      logic             neg;
      logic [WIDTH-1:0] mag;
      logic [15:0]      bcd;
      neg = sgn & v[M];
      mag = neg ? -v : v;
      bcd = bin2bcd({{WIDTH{1'b0}}, mag});
      return {neg ? 4'hA : 4'hF, (bcd[7:4] == 4'h0) ? 4'hF : bcd[7:4], bcd[3:0]};
   endfunction

   // {sign, four digits} for a signed 2*WIDTH-bit value with leading zeros blanked.
   function automatic logic [19:0] fmt4(input logic [W2-1:0] v);
      logic [W2-1:0] mag;
      logic [15:0]   bcd;
      logic [19:0]   r;
      logic          lead;
      mag  = v[W2-1] ? -v : v;
      bcd  = bin2bcd(mag);
      r    = {v[W2-1] ? 4'hA : 4'hF, bcd};
      lead = 1'b1;
      for (int d = 3; d >= 1; d--) begin
         if (lead && (bcd[4*d +: 4] == 4'h0)) r[4*d +: 4] = 4'hF;
         else lead = 1'b0;
      end
      return r;
   endfunction

   logic [4*N_SEGS-1:0] code;

   always_comb begin
      code = {N_SEGS{4'hF}};
      leds = '0;
      if (err_q) begin
         if (banner_on) code[23:4] = 20'hBCCDC;
      end else if (func[2]) begin
         leds        = {a, b};
         code[31:16] = {4'hF, fmt2(b, func[1:0] != 2'b11)};
         code[15:0]  = {4'hF, fmt2(a, func[1:0] != 2'b11)};
      end else begin
         leds = result_q;
         case (op_q)
            2'b11: begin
               code[31:16] = {4'hF, fmt2(result_q[W2-1:WIDTH], 1'b0)};
               code[15:0]  = {4'hF, fmt2(result_q[WIDTH-1:0], 1'b0)};
            end
            2'b10:   code[19:0] = fmt4(result_q);
            default: code[19:0] = fmt4({{WIDTH{result_q[M]}}, result_q[WIDTH-1:0]});
         endcase
      end
   end

   always_comb begin
      segs = '1;
      for (int k = 0; k < N_SEGS; k++) segs[7*k +: 7] = ~bcd2seg(code[4*k +: 4]);
   end

endmodule

// File: tb/tb_alu_seq_top.sv
// Directed, table-driven bench for alu_seq_top (WIDTH=6, N_SEGS=8).
module tb_alu_seq_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  a, b;
   logic [2:0]  func;
   logic        start;
   logic        busy, done, err;
   logic [11:0] leds;
   logic [55:0] segs;
   logic [2:0]  dbg_state;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_seq_top dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .func(func), .start(start),
      .busy(busy), .done(done), .leds(leds), .segs(segs), .err(err),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  func;
      logic [5:0]  a;
      logic [5:0]  b;
      logic [11:0] leds;
      logic        err;
      logic [63:0] disp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Display string, leftmost char = HEX7, rightmost = HEX0.
   function automatic logic [55:0] disp2segs(input logic [63:0] s);
      logic [55:0] r;
      logic [7:0]  ch;
      logic [6:0]  p;
      for (int k = 0; k < 8; k++) begin
         ch = s[8*k +: 8];
         case (ch)
            "0": p = 7'h3F;  "1": p = 7'h06;  "2": p = 7'h5B;  "3": p = 7'h4F;
            "4": p = 7'h66;  "5": p = 7'h6D;  "6": p = 7'h7D;  "7": p = 7'h07;
            "8": p = 7'h7F;  "9": p = 7'h6F;  "-": p = 7'h40;  "E": p = 7'h79;
            "r": p = 7'h50;  "o": p = 7'h5C;  default: p = 7'h00;
         endcase
         r[7*k +: 7] = ~p;
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      a = v.a; b = v.b; func = v.func; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
      check({tag, "_busy_done"}, 64'(busy), 64'd1);
      check({tag, "_leds"}, 64'(leds), 64'(v.leds));
      check({tag, "_err"}, 64'(err), 64'(v.err));
      check({tag, "_segs"}, 64'(segs), 64'(disp2segs(v.disp)));
      @(negedge clk);
      check({tag, "_idle"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int done_seen;
      vecs[0]  = '{3'b000, 6'd5,  6'h3D, 12'h002, 1'b0, "       2", 1};
      vecs[1]  = '{3'b001, 6'd31, 6'h3F, 12'h000, 1'b1, "  Error ", 1};
      vecs[2]  = '{3'b010, 6'h39, 6'd9,  12'hFC1, 1'b0, "   -  63", 6};
      vecs[3]  = '{3'b011, 6'd45, 6'd7,  12'h183, 1'b0, "   6   3", 6};
      vecs[4]  = '{3'b011, 6'd45, 6'd0,  12'h000, 1'b1, "  Error ", 6};
      vecs[5]  = '{3'b001, 6'd3,  6'd10, 12'hFF9, 1'b0, "   -   7", 1};
      vecs[6]  = '{3'b000, 6'h20, 6'h3F, 12'h000, 1'b1, "  Error ", 1};
      vecs[7]  = '{3'b010, 6'h20, 6'h20, 12'h400, 1'b0, "    1024", 6};
      vecs[8]  = '{3'b011, 6'd63, 6'd1,  12'hFC0, 1'b0, "  63   0", 6};
      vecs[9]  = '{3'b010, 6'd0,  6'h3B, 12'h000, 1'b0, "       0", 6};
      vecs[10] = '{3'b001, 6'h20, 6'd1,  12'h000, 1'b1, "  Error ", 1};
      vecs[11] = '{3'b000, 6'd31, 6'd0,  12'h01F, 1'b0, "      31", 1};

      rst = 1'b1; a = '0; b = '0; func = '0; start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_leds", 64'(leds), 64'd0);
      check("reset_segs", 64'(segs), 64'(disp2segs("       0")));

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Live operand display (last op left err=0).
      a = 6'h3B; b = 6'd17; func = 3'b100;
      #1;
      check("live_leds", 64'(leds), 64'hED1);
      check("live_segs_signed", 64'(segs), 64'(disp2segs("  17 - 5")));
      func = 3'b111;
      #1;
      check("live_segs_unsigned", 64'(segs), 64'(disp2segs("  17  59")));

      // Starts during a mul and in its done cycle are dropped.
      @(negedge clk);
      a = 6'h39; b = 6'd9; func = 3'b010; start = 1'b1;
      @(negedge clk);
      a = 6'd1; b = 6'd1; func = 3'b000;
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("ign_latency", 64'(cyc), 64'd6);
      check("ign_leds", 64'(leds), 64'hFC1);
      @(negedge clk);
      start = 1'b0;
      check("ign_done_cycle_start", 64'(busy), 64'd0);
      @(negedge clk);
      check("ign_no_queue_busy", 64'(busy), 64'd0);
      check("ign_no_queue_leds", 64'(leds), 64'hFC1);

      // Reset in the third cycle of a mul discards everything.
      a = 6'h39; b = 6'd9; func = 3'b010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_leds", 64'(leds), 64'd0);
      check("rst_segs", 64'(segs), 64'(disp2segs("       0")));
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("rst_no_done", 64'(done_seen), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
